apu_reg_arbiter: RTL

APU_REG_ARBITER -- requirements
Module: apu_reg_arbiter

---
 rtl/apu_reg_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/apu_reg_arbiter.sv
// APU register-file write arbiter: serialises host and sequencer writes into a flat
// register file, with a level-triggered clear sweep and per-channel reload toggles.
module apu_reg_arbiter #(
   parameter int unsigned NUM_REGS    = 32,
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  host_req_i,
   input  logic [4:0]            host_addr_i,
   input  logic [7:0]            host_data_i,
   output logic                  host_ack_o,
   input  logic                  seq_req_i,
   input  logic [4:0]            seq_addr_i,
   input  logic [7:0]            seq_data_i,
   output logic                  seq_ack_o,
   input  logic                  clear_req_i,
   output logic                  clear_done_o,
   output logic [NUM_REGS*8-1:0] reg_bus_o,
   output logic [3:0]            reg_change_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {StIdle, StWrite, StAck, StClear} state_e;

   state_e                state_q, state_d;
   logic [4:0]            addr_q, addr_d;
   logic [7:0]            data_q, data_d;
   logic                  gnt_seq_q, gnt_seq_d;
   logic                  last_seq_q, last_seq_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [NUM_REGS*8-1:0] regs_q, regs_d;
   logic [3:0]            change_q, change_d;
   logic                  grant_seq;
   logic                  in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         data_q     <= '0;
         gnt_seq_q  <= 1'b0;
         last_seq_q <= 1'b1;
         cnt_q      <= '0;
         regs_q     <= '0;
         change_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         gnt_seq_q  <= gnt_seq_d;
         last_seq_q <= last_seq_d;
         cnt_q      <= cnt_d;
         regs_q     <= regs_d;
         change_q   <= change_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      gnt_seq_d    = gnt_seq_q;
      last_seq_d   = last_seq_q;
      cnt_d        = cnt_q;
      regs_d       = regs_q;
      change_d     = change_q;
      clear_done_o = 1'b0;
      grant_seq    = 1'b0;
      in_range     = ({27'd0, addr_q} < NUM_REGS);

      unique case (state_q)
         StIdle: begin
            if (clear_req_i) begin
               cnt_d   = '0;
               state_d = StClear;
            end else if (host_req_i || seq_req_i) begin
               // On a tie, round-robin favours whoever was not granted last.
               grant_seq  = seq_req_i && (!host_req_i || ((ROUND_ROBIN != 0) && !last_seq_q));
               addr_d     = grant_seq ? seq_addr_i : host_addr_i;
               data_d     = grant_seq ? seq_data_i : host_data_i;
               gnt_seq_d  = grant_seq;
               last_seq_d = grant_seq;
               state_d    = StWrite;
            end
         end
         StWrite: begin
            for (int n = 0; n < NUM_REGS; n++) begin
               if (in_range && (addr_q == 5'(n))) begin
                  regs_d[8*n +: 8] = data_q;
               end
            end
            // Reload registers of the four channels sit at addresses 3, 7, 11, 15.
            if (in_range && !addr_q[4] && (addr_q[1:0] == 2'b11)) begin
               change_d[addr_q[3:2]] = ~change_q[addr_q[3:2]];
            end
            state_d = StAck;
         end
         StAck: begin
            state_d = StIdle;
         end
         StClear: begin
            for (int n = 0; n < NUM_REGS; n++) begin
               if (cnt_q == 5'(n)) begin
                  regs_d[8*n +: 8] = 8'h00;
               end
            end
            if (cnt_q == 5'(NUM_REGS - 1)) begin
               clear_done_o = 1'b1;
               state_d      = StIdle;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign host_ack_o   = (state_q == StAck) && !gnt_seq_q;
   assign seq_ack_o    = (state_q == StAck) && gnt_seq_q;
   assign busy_o       = (state_q != StIdle);
   assign reg_bus_o    = regs_q;
   assign reg_change_o = change_q;

endmodule
